// File: rtl/rfsh_slot_arbiter_pkg.sv
// Shared constants for the refresh-slot read arbiter.
// Holds the FSM state encoding (IDLE, BUSY) and the access-delay counter width.
package rfsh_slot_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: returns the first set mask bit at or after ptr, wrapping.
// Ports:
//   mask  - request mask, one bit per channel
//   ptr   - round-robin start index (0..NUM_CH-1)
//   grant - selected channel index (0 when no bit is set)
//   any   - at least one mask bit is set
module rr_pick #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  grant,
  output logic              any
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    grant = '0;
    any   = |mask;
    idx   = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % NUM_CH;
      if (mask[idx]) grant = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/rfsh_slot_arbiter.sv
// Refresh-slot read arbiter: serves per-channel read requests from a small
// last-address cache, and otherwise issues one SDRAM read per CPU refresh window.
// Ports:
//   clk_sys, nRESET    - clock and synchronous active-low reset
//   nRFSH              - CPU refresh strobe; memory is only accessed while low
//   req, req_addr      - per-channel request strobe and address
//   invalidate         - clears all per-channel cache valid bits
//   ack, rdata         - per-channel completion pulse and held read data
//   mem_rd, mem_addr   - SDRAM read request and address
//   mem_dout           - SDRAM read data
module rfsh_slot_arbiter
  import rfsh_slot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACK_DELAY = 7
) (
  input  logic                     clk_sys,
  input  logic                     nRESET,
  input  logic                     nRFSH,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic                     invalidate,
  output logic [NUM_CH-1:0]        ack,
  output logic [NUM_CH*DATA_W-1:0] rdata,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_dout
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                         state_q, state_d;
  logic [NUM_CH-1:0]              pending_q, pending_d;
  logic [NUM_CH-1:0]              valid_q, valid_d;
  logic [NUM_CH-1:0]              ack_q, ack_d;
  logic [NUM_CH-1:0][ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic [NUM_CH-1:0][ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic                           mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]               grant_q, grant_d;
  logic                           nrfsh_d_q;

  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr_a;
  logic [NUM_CH-1:0]              hit_c;
  logic [NUM_CH-1:0]              miss_c;
  logic                           start_c;
  logic [PTR_W-1:0]               pick_c;
  logic                           pick_any_c;

  assign req_addr_a = req_addr;
  assign start_c    = nrfsh_d_q & ~nRFSH;

  // A pending channel whose address matches its cached one completes without memory.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      hit_c[i] = pending_q[i] & valid_q[i] & (pend_addr_q[i] == last_addr_q[i]);
    end
  end

  assign miss_c = pending_q & ~hit_c;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .mask  (miss_c),
    .ptr   (rr_ptr_q),
    .grant (pick_c),
    .any   (pick_any_c)
  );

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    valid_d     = valid_q;
    ack_d       = '0;
    pend_addr_d = pend_addr_q;
    last_addr_d = last_addr_q;
    rdata_d     = rdata_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;

    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (hit_c[i]) begin
        ack_d[i]     = 1'b1;
        pending_d[i] = 1'b0;
      end
      if (req[i] && !pending_q[i]) begin
        pending_d[i]   = 1'b1;
        pend_addr_d[i] = req_addr_a[i];
      end
    end

    if (invalidate) valid_d = '0;

    case (state_q)
      IDLE: begin
        if (start_c && pick_any_c) begin
          state_d    = BUSY;
          mem_rd_d   = 1'b1;
          mem_addr_d = pend_addr_q[pick_c];
          cnt_d      = CNT_W'(ACK_DELAY);
          grant_d    = pick_c;
        end
      end
      BUSY: begin
        if (nRFSH) begin
          // Window closed early: drop the access, the channel stays pending.
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // Completion on the edge where the counter steps down to 1.
          if (cnt_q == CNT_W'(2)) begin
            state_d              = IDLE;
            mem_rd_d             = 1'b0;
            rdata_d[grant_q]     = mem_dout;
            last_addr_d[grant_q] = pend_addr_q[grant_q];
            valid_d[grant_q]     = 1'b1;
            pending_d[grant_q]   = 1'b0;
            ack_d[grant_q]       = 1'b1;
            rr_ptr_d = (grant_q == PTR_W'(NUM_CH - 1)) ? '0 : grant_q + PTR_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      valid_q     <= '0;
      ack_q       <= '0;
      pend_addr_q <= '0;
      last_addr_q <= '0;
      rdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      nrfsh_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      pend_addr_q <= pend_addr_d;
      last_addr_q <= last_addr_d;
      rdata_q     <= rdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      nrfsh_d_q   <= nRFSH;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rfsh_slot_arbiter.sv
// Directed testbench for rfsh_slot_arbiter (NUM_CH=2, ADDR_W=25, DATA_W=8, ACK_DELAY=7).
module tb_rfsh_slot_arbiter;

  logic        clk_sys;
  logic        nRESET;
  logic        nRFSH;
  logic [1:0]  req;
  logic [49:0] req_addr;
  logic        invalidate;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        mem_rd;
  logic [24:0] mem_addr;
  logic [7:0]  mem_dout;

  int checks   = 0;
  int failures = 0;

  int          rd_cyc, a0_at, a1_at, acks;
  logic [24:0] addr_seen;

  rfsh_slot_arbiter #(
    .NUM_CH    (2),
    .ADDR_W    (25),
    .DATA_W    (8),
    .ACK_DELAY (7)
  ) dut (
    .clk_sys    (clk_sys),
    .nRESET     (nRESET),
    .nRFSH      (nRFSH),
    .req        (req),
    .req_addr   (req_addr),
    .invalidate (invalidate),
    .ack        (ack),
    .rdata      (rdata),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic issue_req(input int ch, input logic [24:0] addr);
    req[ch] = 1'b1;
    req_addr[ch*25 +: 25] = addr;
    tick();
    req = '0;
  endtask

  // Hold nRFSH low for len cycles, then high for a few more, recording activity.
  task automatic run_window(input int len, input logic [7:0] dout,
                            output int rd_cycles, output int ack0_at, output int ack1_at,
                            output int ack_total, output logic [24:0] addr_o);
    rd_cycles = 0; ack0_at = 0; ack1_at = 0; ack_total = 0; addr_o = '0;
    mem_dout = dout;
    nRFSH = 1'b0;
    for (int c = 1; c <= len + 4; c++) begin
      tick();
      if (mem_rd) begin
        rd_cycles++;
        addr_o = mem_addr;
      end
      if (ack[0]) begin
        ack_total++;
        if (ack0_at == 0) ack0_at = c;
      end
      if (ack[1]) begin
        ack_total++;
        if (ack1_at == 0) ack1_at = c;
      end
      if (c == len) nRFSH = 1'b1;
    end
  endtask

  initial begin
    nRESET = 1'b0; nRFSH = 1'b1; req = '0; req_addr = '0;
    invalidate = 1'b0; mem_dout = '0;
    tick(); tick();
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    nRESET = 1'b1;
    tick();

    // Basic read on channel 0.
    issue_req(0, 25'h000100);
    tick(); tick();
    check_eq("basic_no_early_rd", 32'(mem_rd), 32'h0);
    check_eq("basic_no_early_ack", 32'(ack), 32'h0);
    run_window(10, 8'hA5, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("basic_rd_cycles", 32'(rd_cyc), 32'd6);
    check_eq("basic_ack0_cycle", 32'(a0_at), 32'd7);
    check_eq("basic_ack_count", 32'(acks), 32'd1);
    check_eq("basic_addr", 32'(addr_seen), 32'h100);
    check_eq("basic_rdata0", 32'(rdata[7:0]), 32'hA5);

    // Cache hit: same address again, no memory access.
    issue_req(0, 25'h000100);
    check_eq("hit_ack_not_same_cycle", 32'(ack), 32'h0);
    tick();
    check_eq("hit_ack", 32'(ack), 32'h1);
    check_eq("hit_no_rd", 32'(mem_rd), 32'h0);
    tick();
    check_eq("hit_ack_one_pulse", 32'(ack), 32'h0);
    run_window(10, 8'hEE, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("hit_window_no_rd", 32'(rd_cyc), 32'd0);
    check_eq("hit_window_no_ack", 32'(acks), 32'd0);
    check_eq("hit_rdata0_held", 32'(rdata[7:0]), 32'hA5);

    // Round robin: restart from a clean state so the pointer is at channel 0.
    nRESET = 1'b0; tick(); nRESET = 1'b1; tick();
    issue_req(0, 25'h000200);
    issue_req(1, 25'h000300);
    tick();
    run_window(10, 8'h11, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("rr1_ack0", 32'(a0_at), 32'd7);
    check_eq("rr1_no_ack1", 32'(a1_at), 32'd0);
    check_eq("rr1_addr", 32'(addr_seen), 32'h200);
    check_eq("rr1_rdata", 32'(rdata), 32'h0011);
    issue_req(0, 25'h000400);
    tick();
    run_window(10, 8'h22, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("rr2_ack1", 32'(a1_at), 32'd7);
    check_eq("rr2_no_ack0", 32'(a0_at), 32'd0);
    check_eq("rr2_addr", 32'(addr_seen), 32'h300);
    check_eq("rr2_rdata", 32'(rdata), 32'h2211);
    run_window(10, 8'h33, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("rr3_ack0", 32'(a0_at), 32'd7);
    check_eq("rr3_addr", 32'(addr_seen), 32'h400);
    check_eq("rr3_rdata", 32'(rdata), 32'h2233);

    // Abort: short window, then a full one completes the same channel.
    issue_req(1, 25'h000600);
    tick();
    run_window(3, 8'h44, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("abort_rd_cycles", 32'(rd_cyc), 32'd3);
    check_eq("abort_no_ack", 32'(acks), 32'd0);
    check_eq("abort_rdata_kept", 32'(rdata), 32'h2233);
    run_window(10, 8'h55, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("retry_ack1", 32'(a1_at), 32'd7);
    check_eq("retry_rd_cycles", 32'(rd_cyc), 32'd6);
    check_eq("retry_addr", 32'(addr_seen), 32'h600);
    check_eq("retry_rdata", 32'(rdata), 32'h5533);

    // Invalidate: a previously cached address must go to memory.
    invalidate = 1'b1; tick(); invalidate = 1'b0;
    issue_req(0, 25'h000400);
    tick(); tick();
    check_eq("inv_no_hit_ack", 32'(ack), 32'h0);
    run_window(10, 8'h66, rd_cyc, a0_at, a1_at, acks, addr_seen);
    check_eq("inv_ack0", 32'(a0_at), 32'd7);
    check_eq("inv_rd_cycles", 32'(rd_cyc), 32'd6);
    check_eq("inv_rdata", 32'(rdata), 32'h5566);

    // Reset while BUSY at cnt=4.
    issue_req(1, 25'h000700);
    tick();
    mem_dout = 8'h77;
    nRFSH = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("rstb_busy_rd", 32'(mem_rd), 32'h1);
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    check_eq("rstb_rd", 32'(mem_rd), 32'h0);
    check_eq("rstb_ack", 32'(ack), 32'h0);
    check_eq("rstb_rdata", 32'(rdata), 32'h0);
    check_eq("rstb_addr", 32'(mem_addr), 32'h0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack != 2'b00 || mem_rd) acks++;
    end
    check_eq("rstb_quiet_after", 32'(acks), 32'd0);
    nRFSH = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rfsh_slot_arbiter.md
RFSH_SLOT_ARBITER -- requirements
Module: rfsh_slot_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of read requester channels, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 25: SDRAM byte address width.
REQ-003 SHALL have parameter DATA_W, default 8: data width.
REQ-004 SHALL have parameter ACK_DELAY, default 7: cycles from issue to data capture, range 2..15.
REQ-005 SHALL have port clk_sys, input, 1: single system clock; all logic is on its rising edge.
REQ-006 SHALL have port nRESET, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port nRFSH, input, 1: CPU refresh strobe; its low phase is the only window in which memory is accessed.
REQ-008 SHALL have port req, input, NUM_CH: one-cycle request strobe per channel.
REQ-009 SHALL have port req_addr, input, NUM_CH*ADDR_W: per-channel address, sampled on the req strobe.
REQ-010 SHALL have port invalidate, input, 1: clears all per-channel address caches.
REQ-011 SHALL have port ack, output, NUM_CH: one-cycle per-channel completion pulse.
REQ-012 SHALL have port rdata, output, NUM_CH*DATA_W: per-channel read data, valid from ack and held until that channel's next ack.
REQ-013 SHALL have port mem_rd, output, 1: SDRAM read request, to the top-level rd mux.
REQ-014 SHALL have port mem_addr, output, ADDR_W: SDRAM address, to the top-level addr mux.
REQ-015 SHALL have port mem_dout, input, DATA_W: SDRAM read data.

Function
REQ-016 SHALL set pending[i] and capture pend_addr[i] on req[i]; a req[i] arriving while pending[i]=1 SHALL be ignored.
REQ-017 SHALL keep per-channel last_addr[i] and cache valid[i]. When pending[i], valid[i] and pend_addr[i]==last_addr[i], it SHALL pulse ack[i] on the next cycle without a memory access; this applies in any state and to several channels simultaneously.
REQ-018 SHALL register nRFSH one cycle (nRFSH_d). A refresh start is nRFSH_d=1 and nRFSH=0.
REQ-019 SHALL use states IDLE and BUSY for its FSM.
REQ-020 IDLE -> BUSY SHALL occur on refresh start when at least one channel is pending with a cache miss. The grantee SHALL be chosen round-robin: the first missing channel at or after rr_ptr, with wrap-around.
REQ-021 On entering BUSY, the block SHALL set mem_rd=1, set mem_addr=pend_addr[grant] and load cnt=ACK_DELAY.
REQ-022 In BUSY, cnt SHALL decrement by 1 per cycle. At cnt==1 the block SHALL:
- latch mem_dout into rdata[grant] and update last_addr[grant];
- set valid[grant]=1 and clear pending[grant];
- pulse ack[grant];
- set mem_rd=0 and rr_ptr=grant+1 mod NUM_CH;
- return to IDLE.
REQ-023 If nRFSH=1 in BUSY before completion, the block SHALL abort:
- set mem_rd=0 and cnt=0, return to IDLE;
- give no ack; leave pending, last_addr and valid unchanged; leave rr_ptr unchanged;
- retry the channel on the next refresh start.
REQ-024 At most one memory access SHALL be started per refresh window.
REQ-025 invalidate SHALL clear all valid[i] on the next edge. If it coincides with a completion, the completion's valid set SHALL win for that channel only.
REQ-026 mem_addr SHALL hold its last value outside BUSY; mem_rd SHALL be 1 only in BUSY.

Reset
REQ-027 On nRESET=0 at a clock edge, the block SHALL go to IDLE and clear all of the following to 0: pending, valid, last_addr, rdata, ack, mem_rd, mem_addr, cnt, rr_ptr, nRFSH_d.
REQ-028 Reset mid-BUSY SHALL drop mem_rd within the same edge and discard the access without an ack.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, BUSY) and the cnt width constant (4 bits).
REQ-030 The round-robin selector SHALL be one sub-module, rr_pick: inputs mask[NUM_CH] and ptr; outputs grant index and any.
REQ-031 The target implementation size SHALL be 120-400 lines of RTL, with no memories.

Verification
REQ-032 Basic read: NUM_CH=2, req[0] with addr 0x000100, then nRFSH falls for 10 cycles, mem_dout=0xA5 -> mem_rd is high for 6 cycles, ack[0] fires on cycle 7 after the fall, rdata[0]=0xA5.
REQ-033 Cache hit: repeat req[0] with addr 0x000100 -> ack[0] on the next cycle, and mem_rd stays 0.
REQ-034 Round-robin: both channels miss, three refresh windows -> grants are ch0, ch1, then ch0 after a new req[0].
REQ-035 Abort: nRFSH is low only 3 cycles -> mem_rd drops, no ack; the next 10-cycle window completes that channel.
REQ-036 invalidate: assert invalidate, then req[0] with addr 0x000100 -> memory access occurs, no hit ack.
REQ-037 Reset during BUSY: nRESET=0 for 1 cycle at cnt=4 -> mem_rd=0 next edge, no ack, all outputs 0.
